mem_stage_p: RTL

Parametrised memory pipeline stage for the 5-stage MIPS core, sitting between the EX/MEM register and the writeback stage. It owns the unified word-organised data/instruction memory, performs byte/half/word loads and stores with sign or zero extension, and detects misaligned accesses. It models a configurable-latency memory through a stall handshake, and drives the MEM/WB pipeline register.

---
 rtl/mem_stage_p_pkg.sv | 18 +
 rtl/mem_stage_p_if.sv | 38 +++
 rtl/mem_stage_p_lane_align.sv | 53 +++++
 rtl/mem_stage_p.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mem_stage_p_pkg.sv
// mem_pkg: shared encodings for the MEM pipeline stage.
//   SIZE_*  : ex_mem_size access-size codes (2'b11 reserved, behaves as word)
//   state_e : access FSM states
//   LAT_W   : width of the latency wait counter
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned LAT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_p_if.sv
// mem_stage_p_if: EX/MEM -> MEM stage request bundle and MEM/WB result bundle.
//   master : pipeline side, drives ex_mem_*, observes mem_stall and mem_wb_*
//   slave  : memory stage, consumes ex_mem_*, drives mem_stall and mem_wb_*
interface mem_stage_p_if;
  logic        ex_mem_valid;
  logic        ex_mem_selwsource;
  logic        ex_mem_write;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_store_data;
  logic [4:0]  ex_mem_regdest;
  logic        ex_mem_writereg;
  logic [31:0] ex_mem_wbvalue;

  logic        mem_stall;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_regdest;
  logic        mem_wb_writereg;
  logic [31:0] mem_wb_wbvalue;
  logic        mem_wb_misaligned;

  modport master (
    output ex_mem_valid, ex_mem_selwsource, ex_mem_write, ex_mem_size,
           ex_mem_unsigned, ex_mem_addr, ex_mem_store_data, ex_mem_regdest,
           ex_mem_writereg, ex_mem_wbvalue,
    input  mem_stall, mem_wb_valid, mem_wb_regdest, mem_wb_writereg,
           mem_wb_wbvalue, mem_wb_misaligned
  );

  modport slave (
    input  ex_mem_valid, ex_mem_selwsource, ex_mem_write, ex_mem_size,
           ex_mem_unsigned, ex_mem_addr, ex_mem_store_data, ex_mem_regdest,
           ex_mem_writereg, ex_mem_wbvalue,
    output mem_stall, mem_wb_valid, mem_wb_regdest, mem_wb_writereg,
           mem_wb_wbvalue, mem_wb_misaligned
  );
endinterface

// File: rtl/mem_stage_p_lane_align.sv
// mem_lane_align: combinational byte-lane steering for little-endian accesses.
//   addr_lo     : byte offset within the word
//   size        : access size code (mem_pkg::SIZE_*)
//   is_unsigned : zero-extend sub-word loads
//   store_data  : LSB-aligned store data
//   rd_word     : word currently held at the addressed index
//   be          : per-byte write enables
//   wr_word     : store data replicated onto the addressed lanes
//   ld_value    : right-justified, extended load result
//   misaligned  : half on odd byte or word on non-zero offset
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic [31:0] ld_value,
  output logic        misaligned
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be         = 4'b1111;
    wr_word    = store_data;
    ld_byte    = rd_word[8*addr_lo +: 8];
    ld_half    = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    ld_value   = rd_word;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be       = 4'b0001 << addr_lo;
        wr_word  = {4{store_data[7:0]}};
        ld_value = {{24{ld_byte[7] & ~is_unsigned}}, ld_byte};
      end
      SIZE_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word    = {2{store_data[15:0]}};
        ld_value   = {{16{ld_half[15] & ~is_unsigned}}, ld_half};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_p.sv
// mem_stage_p: MEM stage of the 5-stage MIPS core.
//   clock, reset (async, active-low), init_mode (fill pattern during reset)
//   bus (slave): EX/MEM request in, mem_stall and MEM/WB register out
// Holds the unified word memory, the latency FSM and the MEM/WB register.
module mem_stage_p
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          init_mode,
  mem_stage_p_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [LAT_W-1:0] CNT_INIT = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  logic [31:0]    mem_q [DEPTH];
  state_e         state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  logic        valid_q, valid_d;
  logic [4:0]  regdest_q, regdest_d;
  logic        writereg_q, writereg_d;
  logic [31:0] wbvalue_q, wbvalue_d;
  logic        misaligned_q, misaligned_d;

  logic          access;
  logic          stall;
  logic          complete;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wr_word;
  logic [31:0]   ld_value;
  logic          mis;
  logic          mem_we;
  logic          unused_addr;

  assign access      = bus.ex_mem_valid & (bus.ex_mem_selwsource | bus.ex_mem_write);
  assign idx         = bus.ex_mem_addr[AW+1:2];
  // Upper address bits intentionally dropped: addresses wrap modulo DEPTH*4.
  assign unused_addr = ^bus.ex_mem_addr[31:AW+2];

  mem_lane_align u_align (
    .addr_lo     (bus.ex_mem_addr[1:0]),
    .size        (bus.ex_mem_size),
    .is_unsigned (bus.ex_mem_unsigned),
    .store_data  (bus.ex_mem_store_data),
    .rd_word     (mem_q[idx]),
    .be          (be),
    .wr_word     (wr_word),
    .ld_value    (ld_value),
    .misaligned  (mis)
  );

  // Stall is a function of FSM state and request type only.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (LATENCY == 0) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  assign mem_we = complete & bus.ex_mem_write & ~mis;

  always_comb begin
    valid_d      = bus.ex_mem_valid & ~stall;
    regdest_d    = bus.ex_mem_regdest;
    writereg_d   = valid_d & bus.ex_mem_writereg & ~(access & mis);
    misaligned_d = valid_d & access & mis;
    wbvalue_d    = bus.ex_mem_selwsource ? ld_value : bus.ex_mem_wbvalue;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      regdest_q    <= '0;
      writereg_q   <= 1'b0;
      wbvalue_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      regdest_q    <= regdest_d;
      writereg_q   <= writereg_d;
      wbvalue_q    <= wbvalue_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_mode ? 32'(i) : '0;
      end
    end else if (mem_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be[k]) mem_q[idx][8*k +: 8] <= wr_word[8*k +: 8];
      end
    end
  end

  assign bus.mem_stall         = stall;
  assign bus.mem_wb_valid      = valid_q;
  assign bus.mem_wb_regdest    = regdest_q;
  assign bus.mem_wb_writereg   = writereg_q;
  assign bus.mem_wb_wbvalue    = wbvalue_q;
  assign bus.mem_wb_misaligned = misaligned_q;

endmodule
